// File: rtl/obuft_bus_arbiter_if.sv
// Pad-bus arbiter handshake bundle: requests/data in, grant and buffer controls out.
interface obuft_bus_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    logic                  GTS;
    logic [N_REQ-1:0]      REQ;
    logic [N_REQ*DW-1:0]   D_IN;
    logic [N_REQ-1:0]      GNT;
    logic [DW-1:0]         O_DATA;
    logic                  T_PAD;
    logic                  BUSY;

    modport master (
        output GTS, REQ, D_IN,
        input  GNT, O_DATA, T_PAD, BUSY
    );

    modport slave (
        input  GTS, REQ, D_IN,
        output GNT, O_DATA, T_PAD, BUSY
    );
endinterface

// File: rtl/obuft_bus_arbiter.sv
// Round-robin owner arbiter for a shared OBUFT pad bus with a turnaround gap.
// OBUFT_BUS_ARB_PREEMPT_CNT_EN adds a saturating PREEMPT_CNT output.
module obuft_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic CLK,
    input  logic RST_N,
    obuft_bus_arbiter_if.slave bus
`ifdef OBUFT_BUS_ARB_PREEMPT_CNT_EN
    ,
    output logic [15:0] PREEMPT_CNT
`endif
);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD);
    localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]    data_q, data_d;
    logic             t_q, t_d;

    logic [IW-1:0]    win_idx;
    logic [N_REQ-1:0] own_mask;
    logic             others;
    logic             hold_max;
    logic             rel;
    logic             grant;
    int               k;

    always_comb begin
        win_idx = '0;
        k       = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = (int'(rr_q) + i) % N_REQ;
            if (bus.REQ[k]) win_idx = IW'(k);
        end
    end

    assign own_mask = N_REQ'(1) << owner_q;
    assign others   = (bus.REQ & ~own_mask) != '0;
    assign hold_max = hold_q == HW'(MAX_HOLD - 1);
    assign rel      = !bus.REQ[owner_q] || bus.GTS || (hold_max && others);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        t_d     = t_q;
        grant   = 1'b0;
        unique case (state_q)
            S_IDLE: grant = !bus.GTS && (|bus.REQ);
            S_DRIVE: begin
                if (rel) begin
                    state_d = S_TURN;
                    gnt_d   = '0;
                    t_d     = 1'b1;
                    turn_d  = '0;
                    rr_d    = (owner_q == IW'(N_REQ - 1)) ? '0
                                                          : owner_q + 1'b1;
                end else begin
                    data_d = bus.D_IN[int'(owner_q)*DW +: DW];
                    if (!hold_max) hold_d = hold_q + 1'b1;
                end
            end
            S_TURN: begin
                turn_d = turn_q + 1'b1;
                if (turn_q == TW'(TURN - 1)) begin
                    if (!bus.GTS && (|bus.REQ)) grant   = 1'b1;
                    else                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // IDLE and end-of-turnaround share the same grant load
        if (grant) begin
            state_d = S_DRIVE;
            owner_d = win_idx;
            gnt_d   = N_REQ'(1) << win_idx;
            t_d     = 1'b0;
            hold_d  = '0;
            data_d  = bus.D_IN[int'(win_idx)*DW +: DW];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            t_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            t_q     <= t_d;
        end
    end

    assign bus.GNT    = gnt_q;
    assign bus.O_DATA = data_q;
    assign bus.T_PAD  = t_q | bus.GTS;
    assign bus.BUSY   = state_q != S_IDLE;

`ifdef OBUFT_BUS_ARB_PREEMPT_CNT_EN
    logic [15:0] pcnt_q, pcnt_d;
    logic        pre_rel;

    // Only a pure hold-limit release counts, not a drop or GTS
    assign pre_rel = (state_q == S_DRIVE) && hold_max && others
                     && bus.REQ[owner_q] && !bus.GTS;

    always_comb begin
        pcnt_d = pcnt_q;
        if (pre_rel && pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end

    assign PREEMPT_CNT = pcnt_q;
`endif
endmodule
